// File: rtl/uart_host.sv
// uart_host: bus initiator that polls the serial port status register, drains a TX FIFO into
// its data register and, when built with UART_HOST_RX_EN, reads received bytes into a hold register.
module uart_host #(
  parameter int FIFO_AW   = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  output logic               we,
  output logic               enable,
  output logic [1:0]         addr,
  output logic [7:0]         dout,
  input  logic [7:0]         din,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW    = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  localparam logic [GW-1:0]    GAP_INIT = GW'(GAP_TICKS);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POLL  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DATA   = 2'b11;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [7:0]         r_status;
  logic [GW-1:0]      r_gap_cnt;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;

  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_rx_go;
  logic               w_unused;

  assign w_fifo_empty = (r_level == '0);
  assign tx_ready     = (r_level != FULL_LVL);
  assign fifo_level   = r_level;
  assign w_push       = tx_valid & tx_ready;
  assign w_pop        = clken & (r_state == S_WRITE);

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_POLL;
      S_POLL: begin
        if (w_rx_go)                       w_next = S_READ;
        else if (din[2] && !w_fifo_empty)  w_next = S_WRITE;
        else                               w_next = S_POLL;
      end
      S_READ:  w_next = S_POLL;
      S_WRITE: w_next = S_GAP;
      S_GAP:   if (r_gap_cnt <= GAP_ONE) w_next = S_POLL;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_status  <= 8'h00;
      r_gap_cnt <= '0;
    end else if (clken) begin
      r_state <= w_next;
      if (r_state == S_POLL) r_status <= din;
      if (r_state == S_WRITE) begin
        r_gap_cnt <= GAP_INIT;
      end else if (r_state == S_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_ONE;
      end
    end
  end

  // NOTE: FIFO storage is not reset; emptiness is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // Push is not gated by clken, so a byte can land while the FSM is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Bus drive is decoded from the registered state only, so it is stable for the whole state.
  assign enable = (r_state == S_POLL) || (r_state == S_READ) || (r_state == S_WRITE);
  assign we     = (r_state == S_WRITE);
  assign addr   = (r_state == S_POLL)                          ? ADDR_STATUS :
                  (r_state == S_READ || r_state == S_WRITE)    ? ADDR_DATA   : 2'b00;
  assign dout   = (r_state == S_WRITE) ? r_mem[r_rd_ptr] : 8'h00;

`ifdef UART_HOST_RX_EN
  logic       r_rx_valid;
  logic [7:0] r_rx_data;

  // A full hold register blocks READ, so capture and take can never coincide.
  assign w_rx_go = din[0] & ~r_rx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else if (clken && r_state == S_READ) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= din;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign w_unused = ^r_status;
`else
  assign w_rx_go  = 1'b0;
  assign rx_valid = 1'b0;
  assign rx_data  = 8'h00;
  assign w_unused = ^{r_status, rx_ready};
`endif

endmodule

// File: tb/tb_uart_host.sv
// Scoreboard bench for uart_host: stimulus queues expected write bytes, a monitor pops them
// whenever the DUT completes a data-register write, and checks bus timing around each access.
module tb_uart_host;
  localparam int FIFO_AW   = 4;
  localparam int GAP_TICKS = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               clken;
  logic               we;
  logic               enable;
  logic [1:0]         addr;
  logic [7:0]         dout;
  logic [7:0]         din;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [FIFO_AW:0]   fifo_level;

  logic [7:0] port_status;
  logic [7:0] port_rxbyte;
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int clken_mode = 0;

  uart_host #(.FIFO_AW(FIFO_AW), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .reset(reset), .clken(clken), .we(we), .enable(enable), .addr(addr),
    .dout(dout), .din(din), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level)
  );

  // Simple port model: data register on addr 11, status otherwise.
  assign din = (addr == 2'b11) ? port_rxbyte : port_status;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // clken: 0 = tied high, 1 = one in four clocks, 2 = held low.
  initial begin
    int phase;
    phase = 0;
    clken = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      case (clken_mode)
        0:       clken = 1'b1;
        1:       clken = (phase == 0);
        default: clken = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, gap length after each write, bus changes only after a clken edge.
  initial begin
    logic [12:0] prev_bus;
    logic        prev_clken;
    bit          prev_ok;
    bit          after_write;
    int          gap_cnt;
    prev_ok = 0; after_write = 0; gap_cnt = 0; prev_bus = '0; prev_clken = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ok = 0;
        after_write = 0;
      end else begin
        if (prev_ok && {enable, we, addr, dout, 1'b0} != prev_bus)
          check("bus_change_clken", {31'd0, prev_clken}, 32'd1);
        if (enable && after_write) begin
          check("gap_len_ok", {31'd0, gap_cnt >= GAP_TICKS}, 32'd1);
          after_write = 0;
        end else if (!enable && after_write) begin
          gap_cnt++;
        end
        if (enable && we && clken) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got %0h expected none at %0t", dout, $time);
          end else begin
            check("write_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
          end
          n_writes++;
          after_write = 1;
          gap_cnt = 0;
        end
        prev_bus   = {enable, we, addr, dout, 1'b0};
        prev_clken = clken;
        prev_ok    = 1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},         {31'd0, we},         32'd0);
    check({tag, "_enable"},     {31'd0, enable},     32'd0);
    check({tag, "_addr"},       {30'd0, addr},       32'd0);
    check({tag, "_dout"},       {24'd0, dout},       32'd0);
    check({tag, "_tx_ready"},   {31'd0, tx_ready},   32'd1);
    check({tag, "_rx_valid"},   {31'd0, rx_valid},   32'd0);
    check({tag, "_rx_data"},    {24'd0, rx_data},    32'd0);
    check({tag, "_fifo_level"}, {27'd0, fifo_level}, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    repeat (GAP_TICKS + 3) @(negedge clk);
    check("drain_fifo_level", {27'd0, fifo_level}, 32'd0);
  endtask

  task automatic wait_write(input int bound, output bit seen);
    seen = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (enable && we) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic count_reads(input int cycles, output int reads);
    reads = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (enable && !we && addr == 2'b11) reads++;
    end
  endtask

  initial begin
    bit seen;
    int reads;
    int w0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    port_status = 8'h0C; port_rxbyte = 8'h5A;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Three bytes back to back: latency, order, simultaneous push/pop
    #1; tx_valid = 1'b1; tx_data = 8'h41; exp_q.push_back(8'h41);
    @(posedge clk); #1; tx_data = 8'h42; exp_q.push_back(8'h42);
    @(negedge clk);
    check("lat_poll_enable", {31'd0, enable}, 32'd1);
    check("lat_poll_we",     {31'd0, we},     32'd0);
    check("lat_poll_addr",   {30'd0, addr},   32'd1);
    @(posedge clk); #1; tx_data = 8'h43; exp_q.push_back(8'h43);
    @(negedge clk);
    check("lat_write_we",   {31'd0, we},   32'd1);
    check("lat_write_addr", {30'd0, addr}, 32'd3);
    @(posedge clk); #1; tx_valid = 1'b0;
    @(negedge clk);
    check("pushpop_level", {27'd0, fifo_level}, 32'd2);
    check("gap_enable",    {31'd0, enable},     32'd0);
    wait_drain(200);
    check("three_writes", n_writes, 32'd3);

    // Transmitter busy: POLL repeats until tx_rdy rises
    port_status = 8'h00;
    push_byte(8'h77);
    repeat (10) @(negedge clk);
    check("busy_level", {27'd0, fifo_level}, 32'd1);
    check("busy_nowrite", n_writes, 32'd3);
    check("busy_poll_addr", {29'd0, enable, addr}, 32'd5);
    @(posedge clk); #1; port_status = 8'h0C;
    wait_write(2, seen);
    check("busy_release_write", {31'd0, seen}, 32'd1);
    wait_drain(100);

    // Fill FIFO to full with tx_rdy low; 17th byte refused
    port_status = 8'h00;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'h80 + 8'(i);
      @(negedge clk);
      check("fill_tx_ready", {31'd0, tx_ready}, {31'd0, i < 16});
      if (i < 16) exp_q.push_back(8'h80 + 8'(i));
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    @(negedge clk);
    check("full_level",    {27'd0, fifo_level}, 32'd16);
    check("full_tx_ready", {31'd0, tx_ready},   32'd0);
    @(posedge clk); #1; port_status = 8'h0C;
    wait_drain(600);
    check("full_writes", n_writes, 32'd20);

    // Receive path
`ifdef UART_HOST_RX_EN
    port_status = 8'h00;
    push_byte(8'h33);
    repeat (3) @(posedge clk);
    #1; port_status = 8'h0D;
    w0 = n_writes;
    @(negedge clk);
    @(negedge clk);
    check("rx_read_bus", {29'd0, enable, we, addr}, 32'b0111);
    check("rx_read_before_write", n_writes, w0);
    @(negedge clk);
    check("rx_valid_set", {31'd0, rx_valid}, 32'd1);
    check("rx_data_5a",   {24'd0, rx_data},  32'h5A);
    count_reads(12, reads);
    check("rx_no_second_read", reads, 32'd0);
    check("rx_valid_held", {31'd0, rx_valid}, 32'd1);
    @(posedge clk); #1; port_status = 8'h0C; rx_ready = 1'b1;
    @(posedge clk); #1; rx_ready = 1'b0;
    @(negedge clk);
    check("rx_valid_cleared", {31'd0, rx_valid}, 32'd0);
    wait_drain(100);
`else
    port_status = 8'h0D;
    rx_ready = 1'b1;
    push_byte(8'h33);
    count_reads(12, reads);
    check("norx_no_read",  reads, 32'd0);
    check("norx_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("norx_rx_data",  {24'd0, rx_data},  32'd0);
    port_status = 8'h0C;
    rx_ready = 1'b0;
    wait_drain(100);
`endif

    // clken one in four clocks
    w0 = n_writes;
    clken_mode = 1;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    wait_drain(600);
    check("sparse_writes", n_writes - w0, 32'd3);
    clken_mode = 0;
    repeat (4) @(negedge clk);

    // Reset during GAP with five bytes still queued
    port_status = 8'h00;
    for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i));
    port_status = 8'h0C;
    wait_write(5, seen);
    check("rst_first_write", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("rst_in_gap",      {31'd0, enable},     32'd0);
    check("rst_level_before", {27'd0, fifo_level}, 32'd5);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    clken_mode = 2;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_idle", {31'd0, enable}, 32'd0);
    end
    clken_mode = 0;
    @(negedge clk);
    check("rst_idle_until_clken", {31'd0, enable}, 32'd0);
    @(negedge clk);
    check("rst_poll_after_clken", {29'd0, enable, addr}, 32'd5);
    check("rst_level_after", {27'd0, fifo_level}, 32'd0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
